mult_share_arbiter: RTL and testbench

- Shares one pipelined Q2.22 Booth multiplier (opti_multiplier, 14-cycle valid_in→valid_out latency, no backpressure) between NREQ requesters, e.g. the feedforward and feedback coefficient paths of the IIR sections.
- Arbitrates one issue per cycle and registers the operands into the multiplier.
- Tracks each in-flight operation's requester tag in a shift pipeline and routes each product back to the requester that issued it.
- Sits between the biquad control logic and the multiplier.

---
 rtl/mult_share_arbiter.sv | 128 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined Q2.22 multiplier between NREQ requesters,
// with a tag pipeline that routes each product back to its issuer. Option: MULT_SHARE_ARB_PRIO0_EN.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 24,
  parameter int MUL_LAT = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_p,
  output logic               mul_valid_in,
  output logic [DW-1:0]      mul_a,
  output logic [DW-1:0]      mul_b,
  input  logic               mul_valid_out,
  input  logic [DW-1:0]      mul_p,
  output logic               err_seq
);
  localparam int TW = $clog2(NREQ);

  logic [TW-1:0]      ptr_reg, ptr_next;
  logic               grant_any;
  logic [TW-1:0]      grant_idx;
  logic [TW:0]        cand;
  logic               ptr_adv;
  logic [DW-1:0]      sel_a, sel_b;

  logic               mul_valid_in_reg;
  logic [DW-1:0]      mul_a_reg, mul_b_reg;
  logic [TW-1:0]      issue_tag_reg;
  logic               err_seq_reg;

  // The issue registers act as tag stage 0; these MUL_LAT stages follow them so the
  // tail lines up with the multiplier output.
  logic [MUL_LAT-1:0] tag_v_reg;
  logic [TW-1:0]      tag_id_reg [MUL_LAT];
  logic               tail_v;
  logic [TW-1:0]      tail_id;
  logic               route_ok;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_reg} + (TW+1)'(k);
      if (cand >= (TW+1)'(NREQ)) cand = cand - (TW+1)'(NREQ);
      if (!grant_any && req_valid[cand[TW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[TW-1:0];
      end
    end
`ifdef MULT_SHARE_ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
    if (rst) grant_any = 1'b0;
  end

  always_comb begin
    ptr_adv  = grant_any;
`ifdef MULT_SHARE_ARB_PRIO0_EN
    // The priority requester never moves the rotation among the others.
    if (grant_idx == '0) ptr_adv = 1'b0;
`endif
    ptr_next = ptr_reg;
    if (ptr_adv) ptr_next = (grant_idx == TW'(NREQ-1)) ? '0 : grant_idx + TW'(1);
  end

  assign sel_a = req_a[int'(grant_idx)*DW +: DW];
  assign sel_b = req_b[int'(grant_idx)*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg          <= '0;
      mul_valid_in_reg <= 1'b0;
      mul_a_reg        <= '0;
      mul_b_reg        <= '0;
      issue_tag_reg    <= '0;
      err_seq_reg      <= 1'b0;
    end else begin
      ptr_reg          <= ptr_next;
      mul_valid_in_reg <= grant_any;
      if (grant_any) begin
        mul_a_reg     <= sel_a;
        mul_b_reg     <= sel_b;
        issue_tag_reg <= grant_idx;
      end
      if (mul_valid_out != tail_v) err_seq_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_reg <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_id_reg[i] <= '0;
    end else begin
      tag_v_reg     <= {tag_v_reg[MUL_LAT-2:0], mul_valid_in_reg};
      tag_id_reg[0] <= issue_tag_reg;
      for (int i = 1; i < MUL_LAT; i++) tag_id_reg[i] <= tag_id_reg[i-1];
    end
  end

  assign tail_v   = tag_v_reg[MUL_LAT-1];
  assign tail_id  = tag_id_reg[MUL_LAT-1];
  // A product with no matching tag (or a tag with no product) is never routed.
  assign route_ok = mul_valid_out & tail_v & ~rst;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
      assign req_ready[gi] = grant_any && (grant_idx == TW'(gi));
      assign rsp_valid[gi] = route_ok && (tail_id == TW'(gi));
    end
  endgenerate

  assign rsp_p        = mul_p;
  assign mul_valid_in = mul_valid_in_reg;
  assign mul_a        = mul_a_reg;
  assign mul_b        = mul_b_reg;
  assign err_seq      = err_seq_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural 14-cycle Q2.22 multiplier plus a
// queue-based arbitration/response model, randomized and directed scenarios.
module tb_mult_share_arbiter;
  localparam int NREQ    = 4;
  localparam int DW      = 24;
  localparam int MUL_LAT = 14;
  localparam int RSP_LAT = MUL_LAT + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a = '0;
  logic [NREQ*DW-1:0] req_b = '0;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_p;
  logic               mul_valid_in;
  logic [DW-1:0]      mul_a, mul_b;
  logic               mul_valid_out;
  logic [DW-1:0]      mul_p;
  logic               err_seq;
  logic               force_vout = 1'b0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .DW(DW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_p(rsp_p),
    .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid_out(mul_valid_out), .mul_p(mul_p), .err_seq(err_seq)
  );

  function automatic logic [DW-1:0] qmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint pr;
    pr = longint'($signed(a)) * longint'($signed(b));
    pr = pr >>> 22;
    if (pr > 64'sd8388607) return 24'h7FFFFF;
    if (pr < -64'sd8388608) return 24'h800000;
    return pr[23:0];
  endfunction

  // Multiplier stand-in: fixed latency, reset together with the arbiter.
  logic          mp_v [MUL_LAT];
  logic [DW-1:0] mp_p [MUL_LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) mp_v[i] <= 1'b0;
    end else begin
      mp_v[0] <= mul_valid_in;
      mp_p[0] <= qmul(mul_a, mul_b);
      for (int i = 1; i < MUL_LAT; i++) begin
        mp_v[i] <= mp_v[i-1];
        mp_p[i] <= mp_p[i-1];
      end
    end
  end
  assign mul_valid_out = mp_v[MUL_LAT-1] | force_vout;
  assign mul_p         = mp_p[MUL_LAT-1];

  // Reference model
  typedef struct { int due; int req; logic [DW-1:0] p; } rsp_t;
  rsp_t            rsp_q[$];
  int              m_ptr = 0;
  int              m_g;
  int              cyc = 0;
  logic            m_mvi = 1'b0;
  logic [DW-1:0]   m_ma = '0, m_mb = '0;
  logic [NREQ-1:0] exp_ready, exp_rsp_v;
  logic [DW-1:0]   exp_rsp_p, exp_ma, exp_mb;
  logic            exp_mvi;
  int              n_chk = 0, n_fail = 0;

  logic            pend_v [NREQ];
  logic [DW-1:0]   pend_a [NREQ];
  logic [DW-1:0]   pend_b [NREQ];

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
`ifdef MULT_SHARE_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit ptr_moves(input int g);
`ifdef MULT_SHARE_ARB_PRIO0_EN
    return g != 0;
`else
    return g >= 0;
`endif
  endfunction

  task automatic model_eval();
    exp_mvi   = m_mvi;
    exp_ma    = m_ma;
    exp_mb    = m_mb;
    exp_rsp_v = '0;
    exp_rsp_p = '0;
    if (!rst && rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      exp_rsp_v[rsp_q[0].req] = 1'b1;
      exp_rsp_p = rsp_q[0].p;
    end
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) void'(rsp_q.pop_front());
    m_g = rst ? -1 : model_grant(req_valid, m_ptr);
    exp_ready = '0;
    if (m_g >= 0) exp_ready[m_g] = 1'b1;
    if (rst) begin
      rsp_q.delete();
      m_ptr = 0; m_mvi = 1'b0; m_ma = '0; m_mb = '0;
    end else if (m_g >= 0) begin
      rsp_q.push_back('{cyc + RSP_LAT, m_g, qmul(req_a[m_g*DW +: DW], req_b[m_g*DW +: DW])});
      if (ptr_moves(m_g)) m_ptr = (m_g + 1) % NREQ;
      m_mvi = 1'b1;
      m_ma  = req_a[m_g*DW +: DW];
      m_mb  = req_b[m_g*DW +: DW];
    end else begin
      m_mvi = 1'b0;
    end
  endtask

  task automatic drive_pending();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend_v[i];
      req_a[i*DW +: DW]     = pend_a[i];
      req_b[i*DW +: DW]     = pend_b[i];
    end
  endtask

  task automatic set_req(input int i);
    pend_v[i] = 1'b1;
    pend_a[i] = DW'($urandom());
    pend_b[i] = DW'($urandom());
  endtask

  task automatic retire();
    if (m_g >= 0) pend_v[m_g] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    next_cycle();
    for (int i = 0; i < NREQ; i++) set_req(i);
    for (int k = 0; k < 2; k++) begin
      drive_pending();
      @(negedge clk);
      model_eval();
      n_chk++;
      if (req_ready !== 4'b0000 || mul_valid_in !== 1'b0 || mul_a !== 24'h0 || mul_b !== 24'h0 ||
          rsp_valid !== 4'b0000 || err_seq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d ready=%b mvi=%b a=%h b=%h rsp=%b err=%b, required all zero",
                 cyc, req_ready, mul_valid_in, mul_a, mul_b, rsp_valid, err_seq);
      end
      next_cycle();
    end
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    int hs = -100;
    pend_v[0] = 1'b1; pend_a[0] = 24'h200000; pend_b[0] = 24'h200000;
    for (int k = 0; k < 18; k++) begin
      drive_pending();
      @(negedge clk);
      model_eval();
      if (k == 0) begin
        hs = cyc;
        n_chk++;
        if (req_ready !== 4'b0001) begin
          n_fail++; $display("FAIL single_ready got=%b required=0001", req_ready);
        end
      end
      if (cyc == hs + 1) begin
        n_chk++;
        if (mul_valid_in !== 1'b1 || mul_a !== 24'h200000 || mul_b !== 24'h200000) begin
          n_fail++; $display("FAIL single_issue mvi=%b a=%h b=%h required 1/200000/200000", mul_valid_in, mul_a, mul_b);
        end
      end
      if (cyc == hs + RSP_LAT) begin
        n_chk++;
        if (rsp_valid !== 4'b0001 || rsp_p !== 24'h100000) begin
          n_fail++; $display("FAIL single_rsp rsp=%b p=%h required 0001/100000", rsp_valid, rsp_p);
        end
      end
      n_chk++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp_v || (exp_rsp_v != 0 && rsp_p !== exp_rsp_p)) begin
        n_fail++; $display("FAIL single_model cyc=%0d ready=%b/%b rsp=%b/%b p=%h/%h", cyc,
                           req_ready, exp_ready, rsp_valid, exp_rsp_v, rsp_p, exp_rsp_p);
      end
      retire();
      next_cycle();
    end
  endtask

  task automatic test_rotation();
    rst = 1'b1;
    drive_pending();
    @(negedge clk);
    model_eval();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i);
    for (int k = 0; k < 8 + 20; k++) begin
      for (int i = 0; i < NREQ; i++) if (!pend_v[i] && k >= 1 && k <= 4) set_req(i);
      drive_pending();
      @(negedge clk);
      model_eval();
`ifndef MULT_SHARE_ARB_PRIO0_EN
      if (k < 8) begin
        n_chk++;
        if (req_ready !== 4'(1 << (k % NREQ))) begin
          n_fail++; $display("FAIL rotation_grant k=%0d got=%b required=%b", k, req_ready, 4'(1 << (k % NREQ)));
        end
      end
`endif
      n_chk++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp_v || (exp_rsp_v != 0 && rsp_p !== exp_rsp_p) ||
          mul_valid_in !== exp_mvi || mul_a !== exp_ma || mul_b !== exp_mb) begin
        n_fail++; $display("FAIL rotation_model cyc=%0d ready=%b/%b rsp=%b/%b p=%h/%h mvi=%b/%b a=%h/%h b=%h/%h",
                           cyc, req_ready, exp_ready, rsp_valid, exp_rsp_v, rsp_p, exp_rsp_p,
                           mul_valid_in, exp_mvi, mul_a, exp_ma, mul_b, exp_mb);
      end
      retire();
      next_cycle();
    end
  endtask

  task automatic test_partial();
    int hs3 = -100, hs1 = -100;
    set_req(1);
    for (int k = 0; k < 22; k++) begin
      if (k == 1) begin set_req(1); set_req(3); end
      drive_pending();
      @(negedge clk);
      model_eval();
      if (k == 1) begin
        hs3 = cyc;
        n_chk++;
        if (req_ready !== 4'b1000) begin
          n_fail++; $display("FAIL partial_first got=%b required=1000", req_ready);
        end
      end
      if (k == 2) begin
        hs1 = cyc;
        n_chk++;
        if (req_ready !== 4'b0010) begin
          n_fail++; $display("FAIL partial_second got=%b required=0010", req_ready);
        end
      end
      if (cyc == hs3 + RSP_LAT || cyc == hs1 + RSP_LAT) begin
        n_chk++;
        if (rsp_valid !== ((cyc == hs3 + RSP_LAT) ? 4'b1000 : 4'b0010)) begin
          n_fail++; $display("FAIL partial_order cyc=%0d rsp=%b", cyc, rsp_valid);
        end
      end
      n_chk++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp_v || (exp_rsp_v != 0 && rsp_p !== exp_rsp_p)) begin
        n_fail++; $display("FAIL partial_model cyc=%0d ready=%b/%b rsp=%b/%b p=%h/%h", cyc,
                           req_ready, exp_ready, rsp_valid, exp_rsp_v, rsp_p, exp_rsp_p);
      end
      retire();
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 330; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i] && k < 300 && $urandom_range(0, 99) < 50) set_req(i);
      drive_pending();
      @(negedge clk);
      model_eval();
      n_chk++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp_v || (exp_rsp_v != 0 && rsp_p !== exp_rsp_p) ||
          mul_valid_in !== exp_mvi || mul_a !== exp_ma || mul_b !== exp_mb || err_seq !== 1'b0) begin
        n_fail++; $display("FAIL random_model cyc=%0d ready=%b/%b rsp=%b/%b p=%h/%h mvi=%b/%b a=%h/%h b=%h/%h err=%b",
                           cyc, req_ready, exp_ready, rsp_valid, exp_rsp_v, rsp_p, exp_rsp_p,
                           mul_valid_in, exp_mvi, mul_a, exp_ma, mul_b, exp_mb, err_seq);
      end
      retire();
      next_cycle();
    end
  endtask

  task automatic test_reset_inflight();
    set_req(0); set_req(1); set_req(2);
    for (int k = 0; k < 8 + 1 + 20; k++) begin
      rst = (k == 8);
      drive_pending();
      @(negedge clk);
      model_eval();
      if (k > 8) begin
        n_chk++;
        if (rsp_valid !== 4'b0000 || err_seq !== 1'b0 || mul_valid_in !== 1'b0 ||
            mul_a !== 24'h0 || mul_b !== 24'h0) begin
          n_fail++; $display("FAIL rst_inflight cyc=%0d rsp=%b err=%b mvi=%b a=%h b=%h required all zero",
                             cyc, rsp_valid, err_seq, mul_valid_in, mul_a, mul_b);
        end
      end
      n_chk++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp_v) begin
        n_fail++; $display("FAIL rst_inflight_model cyc=%0d ready=%b/%b rsp=%b/%b", cyc,
                           req_ready, exp_ready, rsp_valid, exp_rsp_v);
      end
      retire();
      next_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_err_seq();
    for (int k = 0; k < 8; k++) begin
      force_vout = (k == 0);
      rst        = (k == 6);
      drive_pending();
      @(negedge clk);
      model_eval();
      n_chk++;
      if (rsp_valid !== 4'b0000) begin
        n_fail++; $display("FAIL err_rsp k=%0d rsp=%b required 0000", k, rsp_valid);
      end
      n_chk++;
      if (err_seq !== ((k >= 1 && k <= 6) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL err_sticky k=%0d err=%b required %b", k, err_seq, (k >= 1 && k <= 6));
      end
      next_cycle();
    end
    force_vout = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic test_prio0();
    for (int k = 0; k < 26; k++) begin
      if (k < 6) begin
        if (!pend_v[0]) set_req(0);
        if (!pend_v[2]) set_req(2);
      end
      drive_pending();
      @(negedge clk);
      model_eval();
`ifdef MULT_SHARE_ARB_PRIO0_EN
      if (k < 7) begin
        n_chk++;
        if (req_ready !== ((k < 6) ? 4'b0001 : 4'b0100)) begin
          n_fail++; $display("FAIL prio0_grant k=%0d got=%b", k, req_ready);
        end
      end
`endif
      n_chk++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rsp_v || (exp_rsp_v != 0 && rsp_p !== exp_rsp_p)) begin
        n_fail++; $display("FAIL prio0_model cyc=%0d ready=%b/%b rsp=%b/%b p=%h/%h", cyc,
                           req_ready, exp_ready, rsp_valid, exp_rsp_v, rsp_p, exp_rsp_p);
      end
      retire();
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0;
    end
    test_reset();
    test_single_op();
    test_rotation();
    test_partial();
    test_random();
    test_reset_inflight();
    test_err_seq();
    test_prio0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
